// File: rtl/timer_alarm_core_pkg.sv
// timer_alarm_core_pkg: shared TIMER alarm widths and FSM state encoding.
// Revision: 1.0
`default_nettype none

package timer_alarm_core_pkg;

  localparam int TIMER_DATA_LOW_W  = 32;
  localparam int TIMER_DATA_HIGH_W = 32;

  localparam int ALARM_DATA_W = TIMER_DATA_LOW_W;
  localparam int ALARM_CNT_W  = TIMER_DATA_LOW_W + TIMER_DATA_HIGH_W;
  localparam int ALARM_OVR_W  = 8;

  typedef enum logic [0:0] {
    ALARM_IDLE = 1'b0,
    ALARM_RUN  = 1'b1
  } alarm_state_e;

endpackage

`default_nettype wire

// File: rtl/timer_alarm_irq.sv
// timer_alarm_irq: sticky expiry interrupt with ACK handling and saturating overrun count.
// Revision: 1.0
`default_nettype none

module timer_alarm_irq
  import timer_alarm_core_pkg::*;
#(
  parameter int OVR_W = ALARM_OVR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             expire,
  input  logic             ack,
  output logic             irq,
  output logic [OVR_W-1:0] ovr
);

  localparam logic [OVR_W-1:0] OVR_MAX = '1;

  logic             irq_q, irq_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  always_comb begin
    irq_d = irq_q;
    ovr_d = ovr_q;
    // A fresh expiry outranks ACK for the IRQ, but ACK always clears the overrun count.
    if (expire) begin
      irq_d = 1'b1;
    end else if (ack) begin
      irq_d = 1'b0;
    end
    if (ack) begin
      ovr_d = '0;
    end else if (expire && irq_q && (ovr_q != OVR_MAX)) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
      ovr_q <= '0;
    end else begin
      irq_q <= irq_d;
      ovr_q <= ovr_d;
    end
  end

  assign irq = irq_q;
  assign ovr = ovr_q;

endmodule

`default_nettype wire

// File: rtl/timer_alarm_core.sv
// timer_alarm_core: 2*DATA_W-bit countdown alarm timer, one-shot or periodic.
// Revision: 1.0
`default_nettype none

module timer_alarm_core
  import timer_alarm_core_pkg::*;
#(
  parameter int DATA_W = ALARM_DATA_W,
  parameter int OVR_W  = ALARM_OVR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ALARM_DATA,
  input  logic                ALARM_LOAD_LOW,
  input  logic                ALARM_LOAD_HIGH,
  input  logic                ALARM_PERIODIC,
  input  logic                ALARM_START,
  input  logic                ALARM_STOP,
  input  logic                ALARM_IRQ_ACK,
  output logic                ALARM_IRQ,
  output logic                ALARM_BUSY,
  output logic [2*DATA_W-1:0] ALARM_REMAIN,
  output logic [OVR_W-1:0]    ALARM_OVR
);

  localparam int CNT_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  logic             reload_zero;

  assign reload_zero = (reload_q == '0);

  always_comb begin
    reload_d = reload_q;
    if (ALARM_LOAD_LOW) begin
      reload_d[DATA_W-1:0] = ALARM_DATA;
    end
    if (ALARM_LOAD_HIGH) begin
      reload_d[CNT_W-1:DATA_W] = ALARM_DATA;
    end
  end

  // STOP beats START and expiry; START beats expiry (retrigger).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    case (state_q)
      ALARM_IDLE: begin
        if (ALARM_START && !ALARM_STOP && !reload_zero) begin
          cnt_d   = reload_q;
          state_d = ALARM_RUN;
        end
      end
      ALARM_RUN: begin
        if (ALARM_STOP) begin
          state_d = ALARM_IDLE;
        end else if (ALARM_START) begin
          if (reload_zero) begin
            cnt_d   = '0;
            state_d = ALARM_IDLE;
          end else begin
            cnt_d = reload_q;
          end
        end else if (cnt_q == CNT_ONE) begin
          expire = 1'b1;
          if (ALARM_PERIODIC && !reload_zero) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = ALARM_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ALARM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALARM_IDLE;
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

  timer_alarm_irq #(
    .OVR_W (OVR_W)
  ) u_irq (
    .clk    (clk),
    .rst_n  (rst_n),
    .expire (expire),
    .ack    (ALARM_IRQ_ACK),
    .irq    (ALARM_IRQ),
    .ovr    (ALARM_OVR)
  );

  assign ALARM_BUSY   = (state_q == ALARM_RUN);
  assign ALARM_REMAIN = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_alarm_core.sv
// tb_timer_alarm_core: directed self-checking bench for timer_alarm_core.
// Revision: 1.0
`default_nettype none

module tb_timer_alarm_core;

  localparam int DATA_W = 32;
  localparam int OVR_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   data = '0;
  logic                load_low = 1'b0;
  logic                load_high = 1'b0;
  logic                periodic = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                ack = 1'b0;
  logic                irq;
  logic                busy;
  logic [2*DATA_W-1:0] remain;
  logic [OVR_W-1:0]    ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_alarm_core #(
    .DATA_W (DATA_W),
    .OVR_W  (OVR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ALARM_DATA      (data),
    .ALARM_LOAD_LOW  (load_low),
    .ALARM_LOAD_HIGH (load_high),
    .ALARM_PERIODIC  (periodic),
    .ALARM_START     (start),
    .ALARM_STOP      (stop),
    .ALARM_IRQ_ACK   (ack),
    .ALARM_IRQ       (irq),
    .ALARM_BUSY      (busy),
    .ALARM_REMAIN    (remain),
    .ALARM_OVR       (ovr)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reload(input logic [2*DATA_W-1:0] v);
    data = v[DATA_W-1:0];
    load_low = 1'b1;
    tick();
    load_low = 1'b0;
    data = v[2*DATA_W-1:DATA_W];
    load_high = 1'b1;
    tick();
    load_high = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({irq, busy, remain, ovr} !== '0) begin
      $display("FAIL reset_state: irq=%b busy=%b remain=%h ovr=%0d, required all 0", irq, busy, remain, ovr);
      errors++;
    end
  endtask

  task automatic test_one_shot();
    periodic = 1'b0;
    set_reload(64'd5);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || remain !== 64'd5) begin
      $display("FAIL oneshot_start: busy=%b remain=%0d, required busy=1 remain=5", busy, remain);
      errors++;
    end
    tick(4);
    checks++;
    if (busy !== 1'b1 || remain !== 64'd1 || irq !== 1'b0) begin
      $display("FAIL oneshot_pre_expiry: busy=%b remain=%0d irq=%b, required 1/1/0", busy, remain, irq);
      errors++;
    end
    tick();
    checks++;
    if (busy !== 1'b0 || remain !== 64'd0 || irq !== 1'b1) begin
      $display("FAIL oneshot_expiry: busy=%b remain=%0d irq=%b, required 0/0/1", busy, remain, irq);
      errors++;
    end
    tick(3);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL oneshot_sticky: irq=%b busy=%b, required irq=1 busy=0", irq, busy);
      errors++;
    end
    pulse_ack();
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL oneshot_ack: irq=%b, required 0", irq);
      errors++;
    end
  endtask

  task automatic test_periodic_overrun();
    periodic = 1'b1;
    set_reload(64'd3);
    pulse_start();
    tick(3);
    checks++;
    if (irq !== 1'b1 || ovr !== 8'd0 || busy !== 1'b1 || remain !== 64'd3) begin
      $display("FAIL periodic_first: irq=%b ovr=%0d busy=%b remain=%0d, required 1/0/1/3", irq, ovr, busy, remain);
      errors++;
    end
    tick(3);
    checks++;
    if (ovr !== 8'd1) begin
      $display("FAIL periodic_ovr1: ovr=%0d, required 1", ovr);
      errors++;
    end
    tick(3);
    checks++;
    if (ovr !== 8'd2) begin
      $display("FAIL periodic_ovr2: ovr=%0d, required 2", ovr);
      errors++;
    end
    tick();
    pulse_ack();
    checks++;
    if (irq !== 1'b0 || ovr !== 8'd0 || remain !== 64'd1) begin
      $display("FAIL periodic_ack: irq=%b ovr=%0d remain=%0d, required 0/0/1", irq, ovr, remain);
      errors++;
    end
    tick();
    checks++;
    if (irq !== 1'b1 || ovr !== 8'd0) begin
      $display("FAIL periodic_after_ack: irq=%b ovr=%0d, required 1/0", irq, ovr);
      errors++;
    end
    pulse_stop();
    periodic = 1'b0;
    pulse_ack();
  endtask

  task automatic test_stop_wide();
    set_reload(64'h0000_0001_0000_0002);
    pulse_start();
    tick(4);
    checks++;
    if (remain !== 64'h0000_0000_FFFF_FFFE || busy !== 1'b1) begin
      $display("FAIL wide_borrow: remain=%h busy=%b, required 00000000fffffffe/1", remain, busy);
      errors++;
    end
    pulse_stop();
    checks++;
    if (remain !== 64'h0000_0000_FFFF_FFFE || busy !== 1'b0 || irq !== 1'b0) begin
      $display("FAIL stop_hold: remain=%h busy=%b irq=%b, required 00000000fffffffe/0/0", remain, busy, irq);
      errors++;
    end
    tick(3);
    checks++;
    if (remain !== 64'h0000_0000_FFFF_FFFE || busy !== 1'b0) begin
      $display("FAIL stop_stable: remain=%h busy=%b, required 00000000fffffffe/0", remain, busy);
      errors++;
    end
  endtask

  task automatic test_retrigger();
    set_reload(64'd4);
    pulse_start();
    tick();
    pulse_start();
    checks++;
    if (remain !== 64'd4 || busy !== 1'b1) begin
      $display("FAIL retrigger_reload: remain=%0d busy=%b, required 4/1", remain, busy);
      errors++;
    end
    tick(3);
    checks++;
    if (irq !== 1'b0 || remain !== 64'd1) begin
      $display("FAIL retrigger_no_early_irq: irq=%b remain=%0d, required 0/1", irq, remain);
      errors++;
    end
    tick();
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL retrigger_expiry: irq=%b busy=%b, required 1/0", irq, busy);
      errors++;
    end
    pulse_ack();
  endtask

  task automatic test_simultaneous();
    set_reload(64'd3);
    pulse_start();
    tick(2);
    pulse_stop();
    checks++;
    if (irq !== 1'b0 || remain !== 64'd1 || busy !== 1'b0) begin
      $display("FAIL stop_on_expiry: irq=%b remain=%0d busy=%b, required 0/1/0", irq, remain, busy);
      errors++;
    end
    periodic = 1'b1;
    set_reload(64'd2);
    pulse_start();
    tick(4);
    checks++;
    if (irq !== 1'b1 || ovr !== 8'd1) begin
      $display("FAIL sim_pre_ack: irq=%b ovr=%0d, required 1/1", irq, ovr);
      errors++;
    end
    tick();
    pulse_ack();
    checks++;
    if (irq !== 1'b1 || ovr !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL ack_on_expiry: irq=%b ovr=%0d busy=%b, required 1/0/1", irq, ovr, busy);
      errors++;
    end
    pulse_stop();
    periodic = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || remain !== 64'd2) begin
      $display("FAIL start_stop_idle: busy=%b remain=%0d, required 0/2", busy, remain);
      errors++;
    end
    pulse_ack();
  endtask

  task automatic test_async_reset();
    periodic = 1'b1;
    set_reload(64'd2);
    pulse_start();
    tick(8);
    checks++;
    if (irq !== 1'b1 || ovr !== 8'd3 || busy !== 1'b1) begin
      $display("FAIL pre_reset: irq=%b ovr=%0d busy=%b, required 1/3/1", irq, ovr, busy);
      errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({irq, busy, remain, ovr} !== '0) begin
      $display("FAIL async_reset: irq=%b busy=%b remain=%h ovr=%0d, required all 0", irq, busy, remain, ovr);
      errors++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    tick(2);
    checks++;
    if (busy !== 1'b0 || irq !== 1'b0 || remain !== 64'd0) begin
      $display("FAIL start_zero_reload: busy=%b irq=%b remain=%0d, required 0/0/0", busy, irq, remain);
      errors++;
    end
    periodic = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_overrun();
    test_stop_wide();
    test_retrigger();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_alarm_core.md
Name: timer_alarm_core

Overview:
Programmable countdown/alarm timer. It is the event-generating counterpart to the free-running sampled timer. Software writes a 64-bit reload value in two DATA_W halves and starts the timer. The block counts down and raises a sticky interrupt on expiry, in one-shot or periodic mode. It sits behind the TIMER software register bank, next to the sampled up-counter core.

Parameters:
DATA_W, 32, width of one register half; the counter and reload value are 2*DATA_W bits wide.
OVR_W, 8, width of the saturating overrun counter.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ALARM_DATA  input  DATA_W  write data for the reload halves.
ALARM_LOAD_LOW  input  1  one-cycle strobe: reload[DATA_W-1:0] <= ALARM_DATA.
ALARM_LOAD_HIGH  input  1  one-cycle strobe: reload[2*DATA_W-1:DATA_W] <= ALARM_DATA.
ALARM_PERIODIC  input  1  level: 1 = auto-reload on expiry, 0 = one-shot.
ALARM_START  input  1  one-cycle strobe: (re)start the countdown from reload.
ALARM_STOP  input  1  one-cycle strobe: halt the countdown.
ALARM_IRQ_ACK  input  1  one-cycle strobe: clear the interrupt and the overrun count.
ALARM_IRQ  output  1  sticky expiry interrupt.
ALARM_BUSY  output  1  high while the timer is counting (state RUN).
ALARM_REMAIN  output  2*DATA_W  current counter value, registered.
ALARM_OVR  output  OVR_W  number of expiries while ALARM_IRQ was already set.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; reload=0, counter=0, ALARM_IRQ=0, ALARM_BUSY=0, ALARM_REMAIN=0, ALARM_OVR=0.
- Reload write:
  - LOAD_LOW and LOAD_HIGH in the same cycle write ALARM_DATA into both halves.
  - Writes are legal in any state. They never touch the running counter; a new value takes effect at the next START or periodic reload.
- FSM has two states: IDLE and RUN.
- IDLE:
  - START with reload != 0: counter <= reload, go to RUN.
  - START with reload == 0: ignored, stay IDLE.
- RUN, each cycle without STOP or START: counter <= counter-1.
- Expiry:
  - Occurs on the edge where counter==1. It therefore fires exactly N cycles after the START edge, with N = reload.
  - On expiry ALARM_IRQ <= 1.
  - If ALARM_PERIODIC: counter <= reload and stay RUN, giving period N. If reload was rewritten to 0, go to IDLE with counter=0.
  - Else: counter <= 0, go to IDLE.
- RUN + START (no STOP): retrigger, counter <= reload. If reload==0, go to IDLE.
- RUN + STOP: go to IDLE, counter holds its value (no decrement) so ALARM_REMAIN shows the remaining time. STOP in IDLE has no effect.
- START and STOP in the same cycle: STOP wins.
- STOP and expiry in the same cycle: STOP wins; no IRQ, counter holds 1.
- Overrun:
  - Expiry while ALARM_IRQ==1 and no ACK: ALARM_OVR increments, saturating at 2^OVR_W-1.
  - ACK alone: ALARM_IRQ <= 0, ALARM_OVR <= 0.
  - ACK and expiry in the same cycle: ALARM_IRQ stays 1 (new event), ALARM_OVR <= 0.
- Output timing: all outputs are registered. ALARM_BUSY = (state==RUN), ALARM_REMAIN = counter.
- Width rules: counter arithmetic is unsigned 2*DATA_W. No wrap is possible because the counter never decrements from 0.

Decomposition:
- Shared TIMER package/header holds:
  - the FSM state encoding (IDLE=0, RUN=1)
  - ALARM_* field widths, derived from the TIMER_DATA_LOW_W/HIGH_W definitions
  - the OVR_W default
- One natural sub-module: timer_alarm_irq. It holds the sticky IRQ, the ACK precedence and the saturating overrun counter.
- The countdown and FSM stay in the top.

Test Plan:
1. Reload low=5, high=0, one-shot, START at cycle 0 -> BUSY=1 for cycles 1..5; IRQ rises at cycle 5; REMAIN=0; BUSY=0 after; IRQ stays 1 until ACK.
2. Reload=3, periodic, START, no ACK for 10 cycles -> IRQ at cycle 3; OVR=1 at 6 and 2 at 9; ACK at cycle 11 -> IRQ=0, OVR=0; next IRQ at cycle 12.
3. Reload=0x1_0000_0002 via separate LOW/HIGH writes, START, STOP after 4 cycles -> REMAIN=0x0_FFFF_FFFE, BUSY=0, IRQ=0; REMAIN is stable thereafter.
4. Reload=4, START, then START again at cycle 2 -> counter reset to 4; IRQ at cycle 6, not at cycle 4.
5. Simultaneous events:
   - STOP on the expiry cycle -> no IRQ, REMAIN=1.
   - Periodic reload=2 with ACK on an expiry cycle while IRQ=1 -> IRQ=1, OVR=0.
   - START+STOP together -> stays IDLE.
6. rst_n pulled low mid-RUN with IRQ=1 and OVR=3 -> all outputs 0 immediately (asynchronous). START with reload==0 after reset -> stays IDLE, no IRQ.
